instr_fetch_unit: RTL and testbench

Fetch stage directly upstream of control_unit in the ARM-subset processor. It holds the PC, issues word reads to instruction memory over a req/ack handshake, and buffers fetched words in a small FIFO. It presents instruction[31:0] (control_unit consumes bits 31:12, 6:4) plus its PC to decode, and redirects on pc_src/branch target from the control path.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 92 +++++++++
 tb/tb_instr_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} fetch_state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two depth ring with flush; head read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem req/ack, instruction buffer and branch redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  input  logic        pc_src,
  input  logic [31:0] branch_target
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc, disc_addr, target;
  logic [CW-1:0] count, count_after;
  logic          full, empty, push, pop, slot_after;
  fetch_entry_t  head, push_data;

  assign target      = word_align(branch_target);
  assign pop         = ~empty & instr_ready;
  assign push        = (state == REQ) & imem_ack & ~pc_src;
  assign push_data   = '{word: imem_rdata, pc: fetch_pc};
  // A request is only in flight while count < depth, so count+1 cannot overflow.
  assign count_after = count + CW'(1) - CW'(pop);
  assign slot_after  = (count_after < CW'(FIFO_DEPTH));

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (pc_src),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pc_src || !full) state_nxt = REQ;
      REQ: begin
        if (pc_src)        state_nxt = imem_ack ? REQ : DISCARD;
        else if (imem_ack) state_nxt = slot_after ? REQ : IDLE;
      end
      DISCARD: if (imem_ack) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state != IDLE);
    imem_addr = (state == DISCARD) ? disc_addr : fetch_pc;
  end

  // disc_addr keeps the abandoned address on the bus until its ack drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc  <= RESET_PC;
      disc_addr <= RESET_PC;
    end else begin
      if (pc_src)    fetch_pc <= target;
      else if (push) fetch_pc <= fetch_pc + PC_STEP;
      if (pc_src && state == REQ && !imem_ack) disc_addr <= fetch_pc;
    end
  end

  assign instr_valid = ~empty;
  assign instr       = head.word;
  assign instr_pc    = head.pc;
  assign pc_plus8    = head.pc + PC_READ_OFFSET;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with an imem responder model and a decode consumer.
module tb_instr_fetch_unit;

  logic        clk = 0, reset = 1;
  logic        imem_req, imem_ack = 0;
  logic [31:0] imem_addr, imem_rdata = 0;
  logic        instr_valid, instr_ready = 0;
  logic [31:0] instr, instr_pc, pc_plus8;
  logic        pc_src = 0;
  logic [31:0] branch_target = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .pc_plus8(pc_plus8),
    .pc_src(pc_src), .branch_target(branch_target)
  );

  typedef struct {logic [31:0] w; logic [31:0] pc;} ent_t;
  ent_t sb[$];

  int n_chk = 0, n_err = 0;
  int ack_delay = 0, wait_cnt = 0;
  bit ready_en = 0, spurious = 0, redir = 0, discard = 0;
  bit redir_prev = 0, ack_redir_prev = 0, first_pending = 0, last_req = 0;
  logic [31:0] exp_addr = 0, cur_addr = 0, redir_tgt = 0, first_pc = 0, last_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'hE1A03231 : ((a * 32'h9E3779B1) ^ 32'hE000_0000);
  endfunction

  // One cycle: observe at negedge, then drive inputs for the next posedge.
  task automatic tick();
    ent_t e;
    bit   ack_now;
    @(negedge clk);
    last_req  = imem_req;
    last_addr = imem_addr;
    chk("valid", 32'(instr_valid), 32'(sb.size() != 0));
    if (redir_prev)     chk("flush_valid", 32'(instr_valid), 32'h0);
    if (ack_redir_prev) chk("redir_req", 32'(imem_req), 32'h1);
    ack_now = 0;
    if (imem_req) begin
      if (wait_cnt == 0) begin
        chk("addr", imem_addr, exp_addr);
        chk("slot", 32'(sb.size() < 4), 32'h1);
        cur_addr = imem_addr;
      end else chk("addr_hold", imem_addr, cur_addr);
      if (wait_cnt >= ack_delay) ack_now = 1;
      else wait_cnt++;
    end
    instr_ready = ready_en;
    if (instr_valid && ready_en && sb.size() != 0) begin
      e = sb.pop_front();
      chk("instr", instr, e.w);
      chk("instr_pc", instr_pc, e.pc);
      chk("pc_plus8", pc_plus8, e.pc + 32'd8);
      if (first_pending) begin
        first_pc      = instr_pc;
        first_pending = 0;
      end
    end
    if (ack_now) begin
      wait_cnt   = 0;
      imem_ack   = 1;
      imem_rdata = mem_word(cur_addr);
      if (discard || redir) discard = 0;
      else begin
        sb.push_back('{w: mem_word(cur_addr), pc: cur_addr});
        exp_addr += 32'd4;
      end
    end else begin
      imem_ack   = spurious && !imem_req;
      imem_rdata = $urandom;
    end
    pc_src         = redir;
    branch_target  = redir_tgt;
    ack_redir_prev = redir && ack_now;
    redir_prev     = redir;
    if (redir) begin
      sb.delete();
      exp_addr = redir_tgt & ~32'h3;
      if (imem_req && !ack_now) discard = 1;
      first_pending = 1;
      first_pc      = 32'hFFFF_FFFF;
      redir         = 0;
    end
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redir     = 1;
    redir_tgt = tgt;
    tick();
  endtask

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_pc_plus8", pc_plus8, 32'h8);
    reset = 0;
    tick();
    chk("req_after_rst", 32'(last_req), 32'h1);

    // fill the buffer with decode stalled
    for (int i = 0; i < 20 && sb.size() < 4; i++) tick();
    chk("fill4", 32'(sb.size()), 32'h4);
    spurious = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_full", 32'(last_req), 32'h0);
    end
    chk("head_instr", instr, 32'hE1A03231);
    chk("head_pc", instr_pc, 32'h0);
    chk("head_pc8", pc_plus8, 32'h8);
    spurious = 0;
    ready_en = 1;
    tick();
    ready_en = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (last_req) break;
    end
    chk("resume_req", 32'(last_req), 32'h1);
    chk("resume_addr", last_addr, 32'h10);

    // streaming, then slow memory
    ready_en = 1;
    repeat (12) tick();
    ack_delay = 3;
    repeat (16) tick();

    // redirect while a request is waiting
    for (int i = 0; i < 20 && wait_cnt != 1; i++) tick();
    chk("s5_sync", 32'(wait_cnt), 32'h1);
    redirect_to(32'h103);
    repeat (20) tick();
    chk("redir_first_pc", first_pc, 32'h100);

    // redirect in the same cycle as the ack
    ack_delay = 1;
    for (int i = 0; i < 20 && wait_cnt != 1; i++) tick();
    chk("s6_sync", 32'(wait_cnt), 32'h1);
    redirect_to(32'h2000);
    repeat (10) tick();
    chk("ackredir_first_pc", first_pc, 32'h2000);

    // address and pc_plus8 wrap
    ack_delay = 0;
    redirect_to(32'hFFFF_FFF8);
    repeat (12) tick();
    chk("wrap_first_pc", first_pc, 32'hFFFF_FFF8);

    // async reset with two entries buffered and a request waiting
    ready_en  = 0;
    ack_delay = 3;
    redirect_to(32'h400);
    for (int i = 0; i < 40 && !(sb.size() == 2 && wait_cnt >= 1); i++) tick();
    chk("s7_sync", 32'(sb.size()), 32'h2);
    #2 reset = 1;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'h0);
    chk("arst_req", 32'(imem_req), 32'h0);
    imem_ack   = 1;
    imem_rdata = 32'hDEAD_BEEF;
    pc_src     = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("arst_hold_req", 32'(imem_req), 32'h0);
    chk("arst_hold_addr", imem_addr, 32'h0);
    reset          = 0;
    imem_ack       = 0;
    sb.delete();
    exp_addr       = 0;
    wait_cnt       = 0;
    discard        = 0;
    redir_prev     = 0;
    ack_redir_prev = 0;
    first_pending  = 1;
    first_pc       = 32'hFFFF_FFFF;
    ready_en       = 1;
    ack_delay      = 0;
    tick();
    chk("rerst_req", 32'(last_req), 32'h1);
    repeat (12) tick();
    chk("rerst_first_pc", first_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
